mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, busy duration in cycles for div/divu.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  in  1  E-stage issue strobe; op valid only when high.
REQ-006 md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-007 rs_val  in  32  first operand (dividend/multiplicand; MTHI/MTLO source).
REQ-008 rt_val  in  32  second operand (divisor/multiplier).
REQ-009 busy  out  1  high while an operation is in flight.
REQ-010 hi  out  32  committed HI register.
REQ-011 lo  out  32  committed LO register.

Function
REQ-012 States SHALL be IDLE, MUL, DIV; IDLE -> MUL on accepted MULT/MULTU, IDLE -> DIV on accepted DIV/DIVU, MUL/DIV -> IDLE at edge where counter reaches 0.
REQ-013 Op accepted only when start=1 and state=IDLE; start while busy SHALL be ignored with no state change.
REQ-014 On accepted mult/div: operands' result SHALL be computed from rs_val/rt_val sampled at that edge and held in pending registers; counter loaded with MULT_CYC or DIV_CYC.
REQ-015 busy = (state != IDLE); busy SHALL be high exactly N cycles starting the cycle after the accepting edge (N = MULT_CYC or DIV_CYC).
REQ-016 At the edge counter goes 1 -> 0: hi/lo SHALL update from pending and busy SHALL fall at that same edge.
REQ-017 hi/lo SHALL NOT change during busy; mfhi/mflo consumers read committed values only.
REQ-018 MULT: {hi,lo} = signed 32x32 -> 64 product; MULTU unsigned.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with dividend's sign; DIVU unsigned.
REQ-020 Divide with rt_val=0: accepted, busy for DIV_CYC, hi/lo SHALL remain unchanged at commit.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-022 MTHI/MTLO accepted in IDLE: hi (resp. lo) <= rs_val at that edge; busy stays low; ignored while busy.
REQ-023 md_op NONE or 7 with start=1: no effect.
REQ-024 Counter width SHALL hold max(MULT_CYC, DIV_CYC); parameters SHALL be >= 1.

Reset
REQ-025 reset asserted SHALL immediately force state=IDLE, counter=0, busy=0, hi=0, lo=0, pending=0, regardless of clock.
REQ-026 Reset mid-operation SHALL abort the operation; no commit occurs after release.
REQ-027 First start accepted at first rising edge with reset low.

Structure
REQ-028 Shared package SHALL hold md_op encodings, state encodings, MULT_CYC/DIV_CYC defaults.
REQ-029 Sub-module mdu_arith (combinational: signed/unsigned product, quotient, remainder, div-zero flag) SHALL be instantiated once; sequencing stays in mdu_ctrl.

Verification
REQ-030 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 MULTU rs=0xFFFFFFFF, rt=2 -> busy 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged after 10 cycles.
REQ-033 MULT issued, second DIV start at busy cycle 2 and MTHI at cycle 3 -> both ignored, MULT result committed at cycle 5, busy low thereafter.
REQ-034 DIV issued, reset pulsed at busy cycle 4 between edges -> busy/hi/lo go 0 immediately, no later commit.
REQ-035 MTLO rs=0x12345678 in IDLE -> lo=0x12345678 next edge, busy never asserted, hi unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit controller.
package mdu_ctrl_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MD_OP_W      = 3;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // md_op encodings as presented by the E stage
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // HI/LO pair; a 64-bit product maps directly onto {hi, lo}
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Bits needed for a down-counter that can hold the longer latency
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return 32'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: product, quotient/remainder and divide-by-zero flag.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    output hilo_t           prod_o,
    output hilo_t           divres_o,
    output logic            div_zero_o
);

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   b_div;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;

    // Sign-magnitude divide keeps MIN/-1 well defined and truncates toward zero
    always_comb begin
        a_neg      = signed_i & a_i[XLEN-1];
        b_neg      = signed_i & b_i[XLEN-1];
        a_mag      = a_neg ? (~a_i + XLEN'(1)) : a_i;
        b_mag      = b_neg ? (~b_i + XLEN'(1)) : b_i;
        div_zero_o = (b_i == '0);
        b_div      = div_zero_o ? XLEN'(1) : b_mag;
        q_mag      = a_mag / b_div;
        r_mag      = a_mag % b_div;
        divres_o.lo = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
        divres_o.hi = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
    end

    // Sign- or zero-extend to 64 bits; the low 64 product bits are then exact
    always_comb begin
        a_ext  = {{XLEN{a_neg}}, a_i};
        b_ext  = {{XLEN{b_neg}}, b_i};
        prod_o = a_ext * b_ext;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer owning the architectural HI/LO registers.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [XLEN-1:0]    rs_val,
    input  logic [XLEN-1:0]    rt_val,
    output logic               busy,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYC, DIV_CYC);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hilo_t            hilo_q, hilo_d;
    hilo_t            pend_q, pend_d;
    logic             pend_skip_q, pend_skip_d;

    md_op_e           op_c;
    logic             accept_c;
    logic             last_c;
    logic             signed_c;
    hilo_t            prod_c;
    hilo_t            divres_c;
    logic             div_zero_c;

    // Decode of the issue request
    always_comb begin
        op_c     = md_op_e'(md_op);
        accept_c = start && (state_q == ST_IDLE);
        signed_c = (op_c == MD_MULT) || (op_c == MD_DIV);
        last_c   = (cnt_q <= CNT_W'(1));
    end

    mdu_arith u_arith (
        .a_i        (rs_val),
        .b_i        (rt_val),
        .signed_i   (signed_c),
        .prod_o     (prod_c),
        .divres_o   (divres_c),
        .div_zero_o (div_zero_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on an accepted mult/div, return when the count expires
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (op_c)
                        MD_MULT, MD_MULTU: state_d = ST_MUL;
                        MD_DIV,  MD_DIVU:  state_d = ST_DIV;
                        default:           state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-values: capture on issue, count down while busy, commit on expiry
    always_comb begin
        cnt_d       = cnt_q;
        hilo_d      = hilo_q;
        pend_d      = pend_q;
        pend_skip_d = pend_skip_q;
        if (accept_c) begin
            case (op_c)
                MD_MULT, MD_MULTU: begin
                    pend_d      = prod_c;
                    pend_skip_d = 1'b0;
                    cnt_d       = CNT_W'(MULT_CYC);
                end
                MD_DIV, MD_DIVU: begin
                    pend_d      = divres_c;
                    pend_skip_d = div_zero_c;
                    cnt_d       = CNT_W'(DIV_CYC);
                end
                MD_MTHI: hilo_d.hi = rs_val;
                MD_MTLO: hilo_d.lo = rs_val;
                default: ;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (last_c) begin
                cnt_d = '0;
                // A zero divisor leaves HI/LO untouched
                if (!pend_skip_q) begin
                    hilo_d = pend_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter, pending result and committed HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            hilo_q      <= '0;
            pend_q      <= '0;
            pend_skip_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hilo_q      <= hilo_d;
            pend_q      <= pend_d;
            pend_skip_q <= pend_skip_d;
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        busy = (state_q != ST_IDLE);
        hi   = hilo_q.hi;
        lo   = hilo_q.lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops, monitor checks each visible HI/LO event.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    typedef enum int {EK_BUSY, EK_REG, EK_PROBE} ek_e;

    typedef struct {
        ek_e         kind;
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned blen;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb[$];
    int          n_vec;
    int          n_fail;
    int          probe_req;
    int          probe_done;

    logic        prev_busy;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    int unsigned blen;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_ev(input ek_e k, input string n, input logic [31:0] h,
                             input logic [31:0] l, input int unsigned b);
        exp_t e;
        e.kind = k;
        e.name = n;
        e.hi   = h;
        e.lo   = l;
        e.blen = b;
        sb.push_back(e);
    endtask

    // Present one op for exactly one rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        md_op  = MD_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic probe(input string n, input logic [31:0] h, input logic [31:0] l);
        @(posedge clk);
        #1;
        expect_ev(EK_PROBE, n, h, l, 0);
        probe_req++;
        @(negedge clk);
        #1;
    endtask

    // Monitor: classify what the DUT shows at each falling edge and compare with the queue head
    always @(negedge clk) begin
        logic fall;
        logic chg;
        logic have_ev;
        ek_e  ev;
        exp_t e;
        fall    = prev_busy && !busy;
        chg     = (hi !== prev_hi) || (lo !== prev_lo);
        have_ev = 1'b0;
        ev      = EK_PROBE;
        if (busy) begin
            blen++;
            if (prev_busy) begin
                n_vec++;
                if (chg) begin
                    n_fail++;
                    $display("FAIL hilo_stable_while_busy: hi=%h lo=%h, required hi=%h lo=%h",
                             hi, lo, prev_hi, prev_lo);
                end
            end
        end
        if (fall) begin
            have_ev = 1'b1;
            ev      = EK_BUSY;
        end else if (!busy && chg) begin
            have_ev = 1'b1;
            ev      = EK_REG;
        end else if (!busy && (probe_req != probe_done)) begin
            have_ev = 1'b1;
            ev      = EK_PROBE;
            probe_done++;
        end
        if (have_ev) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: kind=%0d hi=%h lo=%h busy_cycles=%0d, required no event",
                         ev, hi, lo, blen);
            end else begin
                e = sb.pop_front();
                if (e.kind != ev || hi !== e.hi || lo !== e.lo ||
                    (ev == EK_BUSY && blen != e.blen) || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s: kind=%0d hi=%h lo=%h busy_cycles=%0d, required kind=%0d hi=%h lo=%h busy_cycles=%0d",
                             e.name, ev, hi, lo, blen, e.kind, e.hi, e.lo, e.blen);
                end
            end
        end
        if (!busy) blen = 0;
        prev_busy = busy;
        prev_hi   = hi;
        prev_lo   = lo;
    end

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        probe_req  = 0;
        probe_done = 0;
        prev_busy  = 1'b0;
        prev_hi    = '0;
        prev_lo    = '0;
        blen       = 0;
        reset      = 1'b1;
        start      = 1'b0;
        md_op      = MD_NONE;
        rs_val     = '0;
        rt_val     = '0;

        idle(2);
        probe("reset_state", 32'h0, 32'h0);
        reset = 1'b0;

        expect_ev(EK_BUSY, "mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        idle(12);

        expect_ev(EK_BUSY, "multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        idle(12);

        expect_ev(EK_BUSY, "multu_max_sq", 32'hFFFF_FFFE, 32'h0000_0001, 5);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(12);

        expect_ev(EK_BUSY, "mult_min_sq", 32'h4000_0000, 32'h0000_0000, 5);
        issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
        idle(12);

        expect_ev(EK_BUSY, "div_neg7_by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(14);

        expect_ev(EK_BUSY, "divu_by_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIVU, 32'd7, 32'd0);
        idle(14);

        expect_ev(EK_BUSY, "div_7_by_neg2", 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        idle(14);

        expect_ev(EK_BUSY, "divu_max_by16", 32'h0000_000F, 32'h0FFF_FFFF, 10);
        issue(MD_DIVU, 32'hFFFF_FFFF, 32'd16);
        idle(14);

        expect_ev(EK_BUSY, "div_min_by_neg1", 32'h0000_0000, 32'h8000_0000, 10);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(14);

        expect_ev(EK_REG, "mtlo", 32'h0000_0000, 32'h1234_5678, 0);
        issue(MD_MTLO, 32'h1234_5678, 32'h0);
        idle(3);

        expect_ev(EK_REG, "mthi", 32'hCAFE_BABE, 32'h1234_5678, 0);
        issue(MD_MTHI, 32'hCAFE_BABE, 32'h0);
        idle(3);

        issue(MD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MD_RSVD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(3);
        probe("none_rsvd_no_effect", 32'hCAFE_BABE, 32'h1234_5678);

        // DIV at busy cycle 2 and MTHI at busy cycle 3 must both be dropped
        expect_ev(EK_BUSY, "mult_with_ignored_starts", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
        @(posedge clk);
        #1;
        start  = 1'b1;
        md_op  = MD_DIV;
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        md_op  = MD_MTHI;
        rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start  = 1'b0;
        md_op  = MD_NONE;
        idle(8);
        probe("after_ignored_starts", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Reset during busy cycle 4 aborts the divide
        expect_ev(EK_BUSY, "div_reset_abort", 32'h0, 32'h0, 3);
        issue(MD_DIV, 32'd100, 32'd7);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        idle(15);
        probe("no_commit_after_abort", 32'h0, 32'h0);

        expect_ev(EK_BUSY, "multu_after_reset", 32'h0, 32'h0000_000C, 5);
        issue(MD_MULTU, 32'd3, 32'd4);
        idle(12);

        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: pending=%0d, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
